// File: rtl/sr_pkg.sv
// Shared constants and sizing helper for the SR latch front-end.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sr_pkg;

  // Width of the bring-up event counters; they wrap silently.
  localparam int EVT_CNT_W = 8;

  // Flops in each button synchroniser chain.
  localparam int SYNC_STAGES = 2;

  // Smallest width (at least 1) able to hold the values 0 .. value-1.
  // Callers pass max+1 to get a counter that can hold max.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sr_debounce.sv
// Purpose: synchronise, debounce and rising-edge detect one raw button.
// Latency: rise is high DEB_CYCLES+2 edges after din is first sampled high and held.
// Backpressure: none; free-running, one-cycle rise strobe per accepted press.
//
// Ports:
//   clk    - system clock
//   reset  - asynchronous, active-high reset
//   din    - raw asynchronous button level
//   level  - debounced button level
//   rise   - one-cycle strobe: level went 0 -> 1 on the previous edge
module sr_debounce
  import sr_pkg::*;
#(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int CW = clog2(DEB_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          deb_cnt;
  logic                   level_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync    <= '0;
      deb_cnt <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
      rise    <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};

      // The counter only runs while the synchronised input disagrees with
      // the accepted level; any agreement restarts the stability window.
      if (sync[SYNC_STAGES-1] == level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == CW'(DEB_CYCLES - 1)) begin
        level   <= sync[SYNC_STAGES-1];
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + CW'(1);
      end

      // Registered edge detect: only presses produce a strobe.
      level_d <= level;
      rise    <= level & ~level_d;
    end
  end

endmodule

// File: rtl/sr_pulse_gen.sv
// Purpose: turn two raw buttons into programmable-width set/reset pulses for an SR latch.
// Latency: s/r rise DEB_CYCLES+3 edges after the button is first sampled high and held.
// Backpressure: none; a request during an active pulse retriggers it.
//
// Ports:
//   clk, reset        - system clock, asynchronous active-high reset
//   btn_set, btn_rst  - raw asynchronous push buttons, active high
//   s, r              - pulses to the latch, PULSE_W cycles each
//   conflict          - one-cycle flag for simultaneous requests (guard builds only)
//   set_cnt, rst_cnt  - wrap-around counts of pulses started or retriggered
//
// Build option: define SR_CONFLICT_GUARD_EN to make s and r mutually exclusive.
module sr_pulse_gen
  import sr_pkg::*;
#(
  parameter int DEB_CYCLES = 16,
  parameter int PULSE_W    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 btn_set,
  input  logic                 btn_rst,
  output logic                 s,
  output logic                 r,
  output logic                 conflict,
  output logic [EVT_CNT_W-1:0] set_cnt,
  output logic [EVT_CNT_W-1:0] rst_cnt
);

  localparam int PCW = clog2(PULSE_W + 1);

  logic           set_level, rst_level;
  logic           set_rise, rst_rise;
  logic           levels_unused;
  logic           start_set, start_rst;
  logic           kill_set, kill_rst;
  logic           conflict_nxt;
  logic [PCW-1:0] s_cnt, r_cnt;

  sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_set (
    .clk   (clk),
    .reset (reset),
    .din   (btn_set),
    .level (set_level),
    .rise  (set_rise)
  );

  sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_rst (
    .clk   (clk),
    .reset (reset),
    .din   (btn_rst),
    .level (rst_level),
    .rise  (rst_rise)
  );

  // Debounced levels are only of interest on a probe; nothing here consumes them.
  assign levels_unused = set_level ^ rst_level;

  always_comb begin
    start_set    = set_rise;
    start_rst    = rst_rise;
    kill_set     = 1'b0;
    kill_rst     = 1'b0;
    conflict_nxt = 1'b0;
`ifdef SR_CONFLICT_GUARD_EN
    if (set_rise && rst_rise) begin
      // Ambiguous intent: drop both and flag it.
      start_set    = 1'b0;
      start_rst    = 1'b0;
      conflict_nxt = 1'b1;
    end else begin
      // Last request wins: a new request cuts the other channel's pulse short.
      kill_set = rst_rise;
      kill_rst = set_rise;
    end
`endif
  end

  // Outputs decode straight from the down-counters so an asynchronous reset
  // removes an in-flight pulse without waiting for a clock edge.
  assign s = (s_cnt != '0);
  assign r = (r_cnt != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_cnt    <= '0;
      r_cnt    <= '0;
      set_cnt  <= '0;
      rst_cnt  <= '0;
      conflict <= 1'b0;
    end else begin
      conflict <= conflict_nxt;

      if (start_set) begin
        s_cnt   <= PCW'(PULSE_W);
        set_cnt <= set_cnt + EVT_CNT_W'(1);
      end else if (kill_set) begin
        s_cnt <= '0;
      end else if (s_cnt != '0) begin
        s_cnt <= s_cnt - PCW'(1);
      end

      if (start_rst) begin
        r_cnt   <= PCW'(PULSE_W);
        rst_cnt <= rst_cnt + EVT_CNT_W'(1);
      end else if (kill_rst) begin
        r_cnt <= '0;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - PCW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sr_pulse_gen.sv
// Purpose: randomized scoreboard bench for sr_pulse_gen against a behavioural model.
// Latency: model predicts each cycle's outputs when the button values are driven.
// Backpressure: none; a monitor pops one prediction per clock edge.
module tb_sr_pulse_gen;

  localparam int D    = 4;
  localparam int W    = 12;
  localparam int MAXK = 16384;
  localparam int NONE = -100000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_set = 1'b0;
  logic       btn_rst = 1'b0;
  logic       s, r, conflict;
  logic [7:0] set_cnt, rst_cnt;

  always #5 clk = ~clk;

  sr_pulse_gen #(.DEB_CYCLES(D), .PULSE_W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_set  (btn_set),
    .btn_rst  (btn_rst),
    .s        (s),
    .r        (r),
    .conflict (conflict),
    .set_cnt  (set_cnt),
    .rst_cnt  (rst_cnt)
  );

  typedef struct packed {
    logic       s;
    logic       r;
    logic       conflict;
    logic [7:0] set_cnt;
    logic [7:0] rst_cnt;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;

  // Behavioural model: button history per edge, accepted levels, and the
  // edge index at which each channel's current pulse began.
  bit          hist_s[MAXK];
  bit          hist_r[MAXK];
  bit          rise_s[MAXK];
  bit          rise_r[MAXK];
  int          k;
  bit          st_s, st_r;
  int          start_s, start_r, conf_k;
  int unsigned ev_s, ev_r;

  function automatic obs_t cur_obs();
    obs_t o;
    o = {s, r, conflict, set_cnt, rst_cnt};
    return o;
  endfunction

  task automatic check_obs(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got s=%0b r=%0b conflict=%0b set_cnt=%0d rst_cnt=%0d, want s=%0b r=%0b conflict=%0b set_cnt=%0d rst_cnt=%0d",
               name, $time, act.s, act.r, act.conflict, act.set_cnt, act.rst_cnt,
               exp.s, exp.r, exp.conflict, exp.set_cnt, exp.rst_cnt);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s @%0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    k       = 0;
    st_s    = 1'b0;
    st_r    = 1'b0;
    start_s = NONE;
    start_r = NONE;
    conf_k  = NONE;
    ev_s    = 0;
    ev_r    = 0;
  endtask

  // Accepted level flips at edge k when the last D synchronised samples
  // (button values from edges k-2 .. k-1-D) all disagree with it.
  function automatic bit flips(input bit stable, input bit ch);
    bit v;
    for (int j = 2; j <= D + 1; j++) begin
      v = 1'b0;
      if (k - j >= 0) v = ch ? hist_r[k-j] : hist_s[k-j];
      if (v == stable) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Drive the button values sampled at the next edge and predict the outputs after it.
  task automatic drive_edge(input bit bs, input bit br);
    obs_t e;
    bit   req_s, req_r;
    btn_set = bs;
    btn_rst = br;
    hist_s[k] = bs;
    hist_r[k] = br;
    rise_s[k] = 1'b0;
    rise_r[k] = 1'b0;
    if (flips(st_s, 1'b0)) begin st_s = !st_s; rise_s[k] = st_s; end
    if (flips(st_r, 1'b1)) begin st_r = !st_r; rise_r[k] = st_r; end
    // A press is seen by the pulse stage two edges after the level flips.
    req_s = (k >= 2) && rise_s[k-2];
    req_r = (k >= 2) && rise_r[k-2];
`ifdef SR_CONFLICT_GUARD_EN
    if (req_s && req_r) begin
      conf_k = k;
    end else begin
      if (req_s) begin start_s = k; ev_s++; start_r = NONE; end
      if (req_r) begin start_r = k; ev_r++; start_s = NONE; end
    end
`else
    if (req_s) begin start_s = k; ev_s++; end
    if (req_r) begin start_r = k; ev_r++; end
`endif
    e.s        = (k - start_s) < W;
    e.r        = (k - start_r) < W;
    e.conflict = (conf_k == k);
    e.set_cnt  = ev_s[7:0];
    e.rst_cnt  = ev_r[7:0];
    exp_q.push_back(e);
    k++;
  endtask

  task automatic step(input bit bs, input bit br);
    @(negedge clk);
    drive_edge(bs, br);
  endtask

  task automatic hold(input bit bs, input bit br, input int n);
    repeat (n) step(bs, br);
  endtask

  // Monitor: one prediction consumed per clock edge, sampled just after it.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_underflow @%0t: got empty queue, want a prediction", $time);
      end else begin
        check_obs("cycle", cur_obs(), exp_q.pop_front());
      end
    end
  end

  initial begin
    int hs, hr, lat;
    bit ls, lr;
    obs_t zero;
    zero = '0;
    model_reset();

    #12;
    check_obs("reset_state", cur_obs(), zero);

    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;
    drive_edge(1'b0, 1'b0);

    // Directed opening: set press, reset press, short glitch, simultaneous press.
    hold(1'b1, 1'b0, 10);
    hold(1'b0, 1'b0, 20);
    hold(1'b0, 1'b1, 10);
    hold(1'b0, 1'b0, 20);
    hold(1'b1, 1'b0, 3);
    hold(1'b0, 1'b0, 20);
    hold(1'b1, 1'b1, 10);
    hold(1'b0, 1'b0, 20);
    // Reset press landing a few cycles into an active set pulse.
    hold(1'b1, 1'b0, 3);
    hold(1'b1, 1'b1, 8);
    hold(1'b0, 1'b0, 30);

    // Random phase: independent hold times, glitches, and coupled presses.
    hs = 0; hr = 0; ls = 1'b0; lr = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (hs <= 0) begin
        ls = !ls;
        hs = ($urandom_range(9, 0) < 3) ? int'($urandom_range(3, 1)) : int'($urandom_range(14, 5));
        if ($urandom_range(3, 0) == 0) begin
          lr = ls;
          hr = hs;
        end
      end
      if (hr <= 0) begin
        lr = !lr;
        hr = ($urandom_range(9, 0) < 3) ? int'($urandom_range(3, 1)) : int'($urandom_range(14, 5));
      end
      step(ls, lr);
      hs--;
      hr--;
    end
    hold(1'b0, 1'b0, 30);

    // Rapid presses: retrigger back-to-back and wrap set_cnt past 255.
    repeat (270) begin
      hold(1'b1, 1'b0, 5);
      hold(1'b0, 1'b0, 5);
    end
    hold(1'b0, 1'b0, 30);

    // Asynchronous reset in the middle of a set pulse.
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0);
      if (s === 1'b1) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) check_int("wait_for_s_timeout", 0, 1);
    #2;
    mon_en = 1'b0;
    exp_q.delete();
    reset = 1'b1;
    #1;
    check_obs("async_reset_mid_pulse", cur_obs(), zero);

    @(negedge clk);
    reset = 1'b0;
    model_reset();
    mon_en = 1'b1;
    drive_edge(1'b1, 1'b0);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (s === 1'b1 && lat < 0) lat = i - 1;
      drive_edge(1'b1, 1'b0);
    end
    check_int("latency_after_reset", lat, D + 3);
    hold(1'b0, 1'b0, 30);

    @(posedge clk);
    #2;
    mon_en = 1'b0;
    check_int("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sr_pulse_gen.md
Name: sr_pulse_gen

Overview:
Front-end stage that drives the s/r inputs of the SR latch from two raw push-button inputs. Each button is synchronised, debounced and edge-detected, then turned into a set or reset pulse of programmable width. The block also keeps wrap-around event counters for bring-up visibility. Outputs s and r connect directly to the latch's s and r. The latch's reset is driven by the same reset as this block.

Parameters:
DEB_CYCLES, 16, consecutive stable cycles required before a debounced level change is accepted; legal range 1 to 65535.
PULSE_W, 1, width in clk cycles of each s/r pulse; legal range 1 to 255.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
reset  input  1  asynchronous, active-high reset.
btn_set  input  1  raw, asynchronous set button; active high.
btn_rst  input  1  raw, asynchronous reset button; active high.
s  output  1  set pulse to the latch.
r  output  1  reset pulse to the latch.
conflict  output  1  one-cycle flag: set and reset requests arrived in the same cycle. Tied 0 when the optional feature is compiled out.
set_cnt  output  8  number of set pulses issued; wraps 255 to 0.
rst_cnt  output  8  number of reset pulses issued; wraps 255 to 0.

Behaviour:
- Reset (asynchronous, active-high):
  - All registers clear: synchronisers, debounce counters, stable levels, edge registers, pulse counters.
  - Outputs: s=0, r=0, conflict=0, set_cnt=0, rst_cnt=0.
  - Reset asserted mid-pulse aborts the pulse immediately.
  - After reset release, a button already held high is treated as a new press once it has debounced.
- Synchroniser: two flops per button.
- Debounce, per channel:
  - Registered state: stable level plus a counter of width clog2(DEB_CYCLES+1).
  - Synchronised input equals stable: counter clears to 0.
  - Synchronised input differs from stable: counter increments.
  - Counter reaches DEB_CYCLES-1 while the input still differs: stable takes the new value and the counter clears.
  - A glitch shorter than DEB_CYCLES cycles never changes stable.
- Edge detect:
  - A request is a 0-to-1 transition of stable.
  - A 1-to-0 transition (release) produces nothing.
- Latency: s (or r) rises DEB_CYCLES+3 rising edges after btn_set (or btn_rst) is first sampled high and held.
- Pulse generator, per channel:
  - On a request, the output goes to 1 and a down-counter loads PULSE_W.
  - The output stays high for exactly PULSE_W cycles.
  - A new request on the same channel while its pulse is active reloads the counter (retrigger); the event counter still increments.
- Event counters:
  - set_cnt / rst_cnt increment by 1 in the cycle each pulse starts or is retriggered.
  - 8-bit modular arithmetic: 255 wraps to 0 with no flag.
- Without the optional feature: the channels are fully independent, so s=r=1 can occur and is passed to the latch unchanged.

Optional Feature:
Macro: SR_CONFLICT_GUARD_EN.
- Defined: s and r are never 1 in the same cycle.
  - Requests on both channels in the same cycle: both are dropped, no pulse starts, counters are unchanged, and conflict=1 for that one cycle.
  - A request on one channel while the other channel's pulse is active: the active pulse terminates in that cycle and the new pulse starts (last request wins). Only the new channel's counter increments.
- Undefined: no guard logic exists; conflict is constant 0 and both channels run independently.

Decomposition:
- Package sr_pkg holds:
  - EVT_CNT_W = 8.
  - A clog2-style constant function used to size the debounce and pulse counters.
  - Any shared localparams.
- Sub-module sr_debounce contains synchroniser, debounce counter and rising-edge detect. It takes parameter DEB_CYCLES and ports clk, reset, din, level, rise. It is instantiated twice.
- Pulse generation, guard logic and counters live in sr_pulse_gen.

Test Plan:
1. Basic set and reset (DEB_CYCLES=4, PULSE_W=2):
   - btn_set held high from sample edge 0 -> s=1 at edges 7 and 8, s=0 at edge 9; set_cnt=1; r stays 0.
   - Then btn_rst held high -> same timing on r; rst_cnt=1.
2. Glitch rejection (DEB_CYCLES=4): btn_set high for 3 cycles, then low -> s never asserts; set_cnt=0.
3. Retrigger and wrap (PULSE_W=4):
   - A second debounced press that lands while the first pulse is still high -> s stays high continuously and ends 4 cycles after the second request; set_cnt +2.
   - 256 presses -> set_cnt returns to 0.
4. Simultaneous press:
   - Guard defined: btn_set and btn_rst rise in the same cycle -> conflict=1 for one cycle; s=r=0; both counters 0.
   - Guard undefined: s=r=1 for PULSE_W cycles; both counters =1.
5. Overlap, guard defined (PULSE_W=8): rst request 3 cycles into an active set pulse -> s drops in that same cycle, r=1 for 8 cycles, s & r never both 1.
6. Reset mid-pulse: reset asserted asynchronously while s=1 -> s=0 and counters=0 immediately, without waiting for a clk edge. After release with btn_set held high -> a new pulse appears DEB_CYCLES+3 edges later.
